// File: rtl/imem_access_ctrl.sv
// Instruction memory access controller: shares one memory port between
// the fetch (read) path and the program loader (write) path.
module imem_access_ctrl #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    input  logic                  fetch_flush,
    output logic                  fetch_gnt,
    output logic                  fetch_rvalid,
    output logic [DATA_W-1:0]     fetch_rdata,
    output logic                  fetch_err,
    input  logic                  load_req,
    input  logic [31:0]           load_addr,
    input  logic [DATA_W-1:0]     load_wdata,
    output logic                  load_gnt,
    output logic                  load_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    typedef enum logic {
        WIN_FETCH,
        WIN_LOAD
    } win_t;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_t     state_q;
    state_t     state_d;
    win_t       last_win_q;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic       kill_q;
    logic       kill_d;
    logic       fetch_bad;
    logic       load_bad;
    logic       grant_fetch;
    logic       grant_load;
    logic       sel_load;
    logic       rd_done;

    // Misaligned or beyond the memory depth.
    function automatic logic addr_bad(input logic [31:0] a);
        addr_bad = (a[1:0] != 2'b00) || (a[31:DEPTH_LOG2+2] != '0);
    endfunction

    assign fetch_bad = addr_bad(fetch_addr);
    assign load_bad  = addr_bad(load_addr);

    // Round-robin arbiter; grants only from IDLE and never in reset.
    always_comb begin
        grant_fetch = 1'b0;
        grant_load  = 1'b0;
        if (!reset && state_q == IDLE) begin
            if (fetch_req && load_req) begin
                if (last_win_q == WIN_FETCH) begin
                    grant_load = 1'b1;
                end else begin
                    grant_fetch = 1'b1;
                end
            end else begin
                grant_fetch = fetch_req;
                grant_load  = load_req;
            end
        end
    end

    assign fetch_gnt = grant_fetch;
    assign load_gnt  = grant_load;
    assign busy      = (state_q != IDLE);

    // Address/data follow the winner (or the lone requester) to limit toggling.
    assign sel_load  = grant_load || (!grant_fetch && load_req);
    assign mem_addr  = sel_load ? load_addr[DEPTH_LOG2+1:2]
                                : fetch_addr[DEPTH_LOG2+1:2];
    assign mem_wdata = load_wdata;
    assign mem_en    = (grant_fetch && !fetch_bad) || (grant_load && !load_bad);
    assign mem_we    = grant_load && !load_bad;

    // Last RD_WAIT cycle: mem_rdata is valid now and is captured at the edge.
    assign rd_done = (state_q == RD_WAIT) && (cnt_q == 3'd1);

    // Next-state logic: latency countdown and flush bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kill_d  = kill_q;
        unique case (state_q)
            IDLE: begin
                if (grant_fetch && !fetch_bad) begin
                    state_d = RD_WAIT;
                    cnt_d   = LAT;
                    kill_d  = 1'b0;
                end
            end
            RD_WAIT: begin
                if (fetch_flush) begin
                    kill_d = 1'b1;
                end
                if (cnt_q == 3'd1) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, flush flag and arbitration history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            kill_q     <= 1'b0;
            last_win_q <= WIN_FETCH;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
            if (grant_fetch) begin
                last_win_q <= WIN_FETCH;
            end else if (grant_load) begin
                last_win_q <= WIN_LOAD;
            end
        end
    end

    // Response pulses; fetch_rdata only changes when a pulse is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_rvalid <= 1'b0;
            fetch_err    <= 1'b0;
            fetch_rdata  <= '0;
            load_err     <= 1'b0;
        end else begin
            fetch_rvalid <= 1'b0;
            fetch_err    <= 1'b0;
            load_err     <= grant_load && load_bad;
            if (grant_fetch && fetch_bad) begin
                fetch_rvalid <= 1'b1;
                fetch_err    <= 1'b1;
                fetch_rdata  <= '0;
            end else if (rd_done && !kill_q && !fetch_flush) begin
                fetch_rvalid <= 1'b1;
                fetch_rdata  <= mem_rdata;
            end
        end
    end

endmodule
